// File: rtl/bit_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder_if
// Purpose  : Operand/result valid-ready bundle for the bit-serial adder.
// Revision : 1.0
// ============================================================================
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface
`default_nettype wire

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder
// Purpose  : LSB-first bit-serial adder around a single full-adder bit cell.
// Revision : 1.0
// ============================================================================
module full_adder_cell (
  input  logic X1,
  input  logic X2,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = X1 ^ X2 ^ Cin;
  assign Cout = (X1 & X2) | (X1 & Cin) | (X2 & Cin);
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bit_serial_adder_if.slave bus
);
  localparam int                CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] s_sh_q;
  logic [WIDTH-1:0] s_sh_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fa_s;
  logic             fa_co;

  full_adder_cell u_fa (
    .X1  (a_sh_q[0]),
    .X2  (b_sh_q[0]),
    .Cin (carry_q),
    .S   (fa_s),
    .Cout(fa_co)
  );

  // A one-bit result register has no upper part to shift down.
  generate
    if (WIDTH == 1) begin : g_sh_w1
      assign s_sh_d = fa_s;
    end else begin : g_sh_wn
      assign s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q <= fa_co;
          s_sh_q  <= s_sh_d;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST) begin
            sum_q   <= s_sh_d;
            cout_q  <= fa_co;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status is gated by rst_n so it reads inactive for the whole reset window.
  assign bus.in_ready  = rst_n & (state_q == IDLE);
  assign bus.out_valid = rst_n & (state_q == DONE);
  assign bus.busy      = rst_n & (state_q == RUN);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule
`default_nettype wire

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial multi-bit adder that sits directly upstream of the team's single-bit full-adder cell. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then feeds one bit pair per clock, LSB first, into a full-adder bit cell. A carry flip-flop closes the loop between cycles. The result is returned as a WIDTH-bit sum plus carry-out over a second valid/ready handshake.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands on a/b/cin are valid
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  sum/cout hold a completed result
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  output  1  bit WIDTH of (a + b + cin)
- busy  output  1  high in RUN

## Operation
- Bit cell equations: s = x1 ^ x2 ^ c; co = x1&x2 | x1&c | x2&c. The team's full-adder cell (ports X1, X2, Cin, S, Cout) is instantiated for this.
- Internal state:
  - a_sh, b_sh: WIDTH-bit shift registers.
  - s_sh: WIDTH-bit result shift register.
  - carry: 1-bit flip-flop.
  - cnt: counter, $clog2(WIDTH+1) bits.
  - state: IDLE, RUN or DONE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid & in_ready: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, the bit cell sees x1=a_sh[0], x2=b_sh[0], c=carry.
  - Updates per cycle: carry<=co; s_sh<={s, s_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; cnt<=cnt+1.
  - When cnt==WIDTH-1, this is the last bit:
    - sum<={s, s_sh[WIDTH-1:1]}
    - cout<=co
    - state<=DONE
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_valid & out_ready: state<=IDLE.
- in_valid while not in IDLE is ignored. No operand is queued.
- sum and cout registers keep the last result until the next completion. They are valid only while out_valid=1.
- Reset (rst_n=0 at a rising edge):
  - state<=IDLE.
  - sum, cout, carry, cnt, a_sh, b_sh and s_sh all <=0.
- While rst_n=0: in_ready=0, out_valid=0, busy=0.
- Reset in mid-RUN or in DONE abandons the operation. No out_valid is produced for it.

## Timing
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Acceptance at edge E0. Bits 0..WIDTH-1 are processed in the cycles ending at edges E0+1..E0+WIDTH.
- out_valid rises after edge E0+WIDTH. Latency from accept to out_valid is WIDTH cycles.
- Result handshake at edge E1. in_ready is 1 in the cycle after E1, so the earliest next acceptance is E1+1.
- Throughput with out_ready tied high: one result per WIDTH+2 cycles (accept, WIDTH RUN, 1 DONE).
- Out of reset: in_ready=1 in the first cycle with rst_n=1.
- out_ready held low: DONE persists indefinitely with sum/cout unchanged.
- WIDTH=1: RUN lasts exactly 1 cycle.

## Test plan
- Reset: rst_n low for 2 edges with in_valid=1 -> in_ready=0, out_valid=0, sum=0, cout=0 throughout. After release, in_ready=1 and there is no spurious acceptance during reset.
- WIDTH=8 directed vectors, out_ready=1. out_valid must rise exactly 8 cycles after acceptance.
  - a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, cout=0.
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Back-pressure: result a=8'h10, b=8'h20, cin=0 with out_ready=0 for 5 cycles -> out_valid=1, sum=8'h30 and cout=0 stable, in_ready=0. in_valid pulses with other operands are ignored. Raising out_ready completes the handshake, and in_ready=1 the next cycle.
- Reset mid-operation: accept a=8'hAA, b=8'h55, then rst_n=0 at RUN cycle 3 -> out_valid never asserts, sum=0, and in_ready=1 the first cycle after release. A following add 8'h01+8'h01+0 returns sum=8'h02, cout=0.
- WIDTH=1 truth table: all 8 combinations of a, b, cin -> {cout,sum} equals a+b+cin, e.g. 1,1,1 -> cout=1, sum=1. Each result arrives 1 cycle after acceptance.
- Randomised WIDTH=8 and WIDTH=32: 1000 back-to-back operands with random out_ready stalls -> every {cout,sum} equals a+b+cin, with no lost or duplicated results.
